// File: rtl/countdown_timer.sv
// Loadable down-counting timer: a prescaler turns clk into unit ticks and each
// tick decrements the count; reaching zero pulses done and latches expired (or reloads).
module countdown_timer #(
  parameter int unsigned TICKS       = 50_000_000,
  parameter int unsigned WIDTH       = 10,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] out,
  output logic             running,
  output logic             done,
  output logic             expired
);

  localparam int unsigned PW = $clog2(TICKS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] reload, reload_n, out_n;
  logic [PW-1:0]    presc, presc_n;
  logic             done_n, expired_n;

  // NOTE: every target gets a default before the branches so no path leaves
  // a value unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    state_n   = state;
    out_n     = out;
    reload_n  = reload;
    presc_n   = presc;
    done_n    = 1'b0;
    expired_n = expired;

    if (load) begin
      out_n     = load_val;
      reload_n  = load_val;
      presc_n   = '0;
      state_n   = IDLE;
      expired_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && out != '0) begin
            state_n = RUN;
            presc_n = '0;
          end
        end
        RUN: begin
          if (pause) begin
            state_n = PAUSED;
          end else if (presc == PRESC_MAX) begin
            presc_n = '0;
            if (out > WIDTH'(1)) begin
              out_n = out - WIDTH'(1);
            end else if (out == WIDTH'(1)) begin
              done_n = 1'b1;
              // A zero reload register would spin forever at zero, so it expires instead.
              if (AUTO_RELOAD && reload != '0) begin
                out_n = reload;
              end else begin
                out_n     = '0;
                state_n   = EXPIRED;
                expired_n = 1'b1;
              end
            end
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        PAUSED: begin
          if (start && !pause) state_n = RUN;
        end
        EXPIRED: begin
          out_n     = '0;
          expired_n = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      out     <= '0;
      reload  <= '0;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      out     <= out_n;
      reload  <= reload_n;
      presc   <= presc_n;
      running <= (state_n == RUN);
      done    <= done_n;
      expired <= expired_n;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICKS=4: one instance without and one
// with auto-reload, sharing stimulus; expected values are hand-computed constants.
module tb_countdown_timer;

  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;

  logic [W-1:0] out, out_ar;
  logic         running, done, expired;
  logic         running_ar, done_ar, expired_ar;

  int n_cmp = 0;
  int n_err = 0;

  countdown_timer #(.TICKS(4), .WIDTH(W), .AUTO_RELOAD(1'b0)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .pause(pause),
    .out(out), .running(running), .done(done), .expired(expired)
  );

  countdown_timer #(.TICKS(4), .WIDTH(W), .AUTO_RELOAD(1'b1)) dut_ar (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .pause(pause),
    .out(out_ar), .running(running_ar), .done(done_ar), .expired(expired_ar)
  );

  always #5 clk = ~clk;

  // Packed view {out, running, done, expired} for compact comparisons.
  function automatic logic [31:0] st(input logic [W-1:0] o, input logic r,
                                     input logic d, input logic e);
    return {19'd0, o, r, d, e};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1;
    load_val = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int exp_edges;

    // 1: reset and ignored start with count 0
    step(2);
    check("reset_low", st(out, running, done, expired), st(0, 0, 0, 0));
    #3 rst = 1'b1;
    step();
    check("reset_release", st(out, running, done, expired), st(0, 0, 0, 0));
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("start_zero_ignored", st(out, running, done, expired), st(0, 0, 0, 0));

    // 2: load 3, count to expiry
    do_load(3);
    check("load3", st(out, running, done, expired), st(3, 0, 0, 0));
    start = 1'b1;
    step();                                            // E0
    start = 1'b0;
    check("run_E0", st(out, running, done, expired), st(3, 1, 0, 0));
    step(3);
    check("hold_E3", st(out, running, done, expired), st(3, 1, 0, 0));
    step();
    check("tick_E4", st(out, running, done, expired), st(2, 1, 0, 0));
    step(4);
    check("tick_E8", st(out, running, done, expired), st(1, 1, 0, 0));
    step(3);
    check("pre_E11", st(out, running, done, expired), st(1, 1, 0, 0));
    step();
    check("expire_E12", st(out, running, done, expired), st(0, 0, 1, 1));
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      step();
      check("expired_hold", st(out, running, done, expired), st(0, 0, 0, 1));
    end
    start = 1'b0;

    // 3: pause / resume preserving the partial tick
    do_load(5);
    check("load5_clears_expired", st(out, running, done, expired), st(5, 0, 0, 0));
    start = 1'b1;
    step();                                            // E0
    start = 1'b0;
    step(4);
    check("p_tick_E4", st(out, running, done, expired), st(4, 1, 0, 0));
    step(2);                                           // E6
    pause = 1'b1;
    step();                                            // E7 stalled edge
    check("pause_enter", st(out, running, done, expired), st(4, 0, 0, 0));
    for (int i = 0; i < 9; i++) begin                  // E8..E16
      step();
      check("pause_frozen", st(out, running, done, expired), st(4, 0, 0, 0));
    end
    start = 1'b1;                                      // pause + start together
    step();                                            // E17
    check("pause_beats_start", st(out, running, done, expired), st(4, 0, 0, 0));
    pause = 1'b0;
    step();                                            // E18 resume
    start = 1'b0;
    check("resume", st(out, running, done, expired), st(4, 1, 0, 0));
    // 20 RUN edges + 11 paused edges (E8..E18) + 1 stalled edge (E7)
    exp_edges = 20 + 11 + 1;
    k = 18;
    while (done !== 1'b1 && k < 60) begin
      step();
      k++;
    end
    check("pause_done_edge", k, exp_edges);
    check("pause_expire_state", st(out, running, done, expired), st(0, 0, 1, 1));

    // 4: auto-reload sequence on dut_ar
    do_load(2);
    start = 1'b1;
    step();                                            // E0
    start = 1'b0;
    check("ar_E0", st(out_ar, running_ar, done_ar, expired_ar), st(2, 1, 0, 0));
    for (int e = 1; e <= 24; e++) begin
      step();
      check("ar_seq", st(out_ar, running_ar, done_ar, expired_ar),
            st(((e / 4) % 2 == 0) ? W'(2) : W'(1), 1'b1, (e % 8 == 0), 1'b0));
    end

    // 5: load on the same edge as a tick
    do_load(8);
    start = 1'b1;
    step();                                            // E0
    start = 1'b0;
    step(4);
    check("l_out7", st(out, running, done, expired), st(7, 1, 0, 0));
    step(3);                                           // prescaler now at 3
    load = 1'b1;
    load_val = 9;
    step();                                            // tick edge overridden
    load = 1'b0;
    check("load_over_tick", st(out, running, done, expired), st(9, 0, 0, 0));
    start = 1'b1;
    step();
    start = 1'b0;
    step(3);
    check("l_no_early_tick", st(out, running, done, expired), st(9, 1, 0, 0));
    step();
    check("l_first_dec", st(out, running, done, expired), st(8, 1, 0, 0));

    // 6: asynchronous reset mid-count
    do_load(4);
    start = 1'b1;
    step();
    start = 1'b0;
    step(4);
    check("r_out3", st(out, running, done, expired), st(3, 1, 0, 0));
    #2 rst = 1'b0;
    #1;
    check("async_reset", st(out, running, done, expired), st(0, 0, 0, 0));
    step();
    check("reset_held", st(out, running, done, expired), st(0, 0, 0, 0));
    #3 rst = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("no_resume_after_reset", st(out, running, done, expired), st(0, 0, 0, 0));
    do_load(1);
    start = 1'b1;
    step();                                            // E0
    start = 1'b0;
    step(3);
    check("r1_pre", st(out, running, done, expired), st(1, 1, 0, 0));
    step();
    check("r1_done", st(out, running, done, expired), st(0, 0, 1, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable down-counting timer, the counterpart to the team's free-running up-counting seconds timer. A prescaler divides clk into unit ticks of TICKS cycles; each tick decrements a WIDTH-bit count. On reaching zero the block pulses done and raises a sticky expired flag, or reloads when AUTO_RELOAD=1. Used for timeouts and countdown displays driven by control FSMs.

Parameters:
TICKS, 50_000_000, clk cycles per unit tick (one second at 50 MHz); must be >= 2
WIDTH, 10, width of load_val and out
AUTO_RELOAD, 0, 1 = on expiry reload the last loaded value and keep running; 0 = stop in EXPIRED

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
load  input  1  capture load_val into count and reload register; highest priority
load_val  input  WIDTH  value captured on load
start  input  1  begin counting from IDLE, or resume from PAUSED
pause  input  1  freeze counting while in RUN
out  output  WIDTH  current count (registered)
running  output  1  high while state == RUN
done  output  1  one-cycle pulse when count reaches terminal
expired  output  1  sticky; high in EXPIRED until load or reset

Behaviour:
- Reset (rst low, asynchronous): state IDLE, out=0, reload register=0, prescaler=0, running=0, done=0, expired=0.
- Prescaler width is $clog2(TICKS). It counts 0..TICKS-1 only in RUN; a tick occurs on the edge where prescaler==TICKS-1 (prescaler returns to 0). Ticks are exactly TICKS cycles apart.
- States: IDLE, RUN, PAUSED, EXPIRED. All outputs are registered; done defaults to 0 every cycle.
- load=1 (any state): out<=load_val, reload<=load_val, prescaler<=0, state<=IDLE, expired<=0, done<=0. It overrides start, pause and any same-cycle tick.
- IDLE: start=1 with out!=0 -> RUN, prescaler<=0. start with out==0 is ignored (stay IDLE). pause is ignored.
- RUN, pause=1: -> PAUSED. Prescaler and out hold, with no tick that edge even if prescaler==TICKS-1. pause beats a simultaneous start.
- RUN, pause=0: prescaler advances. On a tick with out>1, out<=out-1. On a tick with out==1:
  - AUTO_RELOAD=0: out<=0, state<=EXPIRED, done<=1 for one cycle, expired<=1.
  - AUTO_RELOAD=1: out<=reload, stay RUN, done<=1 for one cycle, expired stays 0. If reload==0, treat as AUTO_RELOAD=0 behaviour.
- PAUSED: start=1 and pause=0 -> RUN with the prescaler value preserved (partial tick resumes). Otherwise hold.
- EXPIRED: out=0, expired=1. start and pause are ignored. Only load or reset leaves.
- out never wraps below 0. Decrement is plain WIDTH-bit subtraction, guarded by out!=0.
- Reset asserted mid-count aborts immediately to reset values. Counting resumes only after a new load and start.

Test Plan:
(Run with TICKS=4, WIDTH=10 unless noted.)
1. Assert rst low, then release -> out=0, running=0, done=0, expired=0. Pulse start -> stays IDLE, running=0.
2. load 3; start at edge E0 -> running=1. out=2 after E4, 1 after E8, 0 after E12. done high exactly one cycle after E12. expired=1, running=0 and out=0 held for 20 further cycles, with start pulses ignored.
3. load 5; start; pause after 6 RUN cycles; hold pause 10 cycles; pause and start together (stays PAUSED); then start alone -> expiry done lands exactly 20 RUN cycles after the first start, plus paused cycles plus the one stalled cycle. out frozen at 4 throughout the pause.
4. AUTO_RELOAD=1: load 2; start -> out sequence 2,1,2,1,... changing every 4 cycles. done pulses every 8 cycles. expired never asserts and running stays 1.
5. During RUN with out=7, assert load with load_val=9 on the same cycle as a tick -> out=9, state IDLE, prescaler 0, no done. Then start -> first decrement 4 cycles later.
6. Drop rst low asynchronously mid-cycle during RUN (out=3) -> all outputs zero immediately, without waiting for a clk edge. Then load 1; start -> done after 4 cycles.
